// File: rtl/difficulty_pkg.sv
// Shared difficulty types and the level/display mappings used by the
// scheduler and by the HEX display side.
package difficulty_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    OVER = 2'd2
  } state_t;

  typedef logic [1:0] level_t;

  localparam level_t MAX_LEVEL = 2'd3;

  // Three bits can never count past 3, so the saturation to MAX_LEVEL is inherent.
  function automatic level_t popcount3(input logic [2:0] v);
    level_t s;
    s = {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
    return s;
  endfunction

  function automatic logic [2:0] therm_encode(input level_t l);
    logic [2:0] code;
    case (l)
      2'd0:    code = 3'b000;
      2'd1:    code = 3'b001;
      2'd2:    code = 3'b011;
      default: code = 3'b111;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/difficulty_scheduler_step_timer.sv
// Programmable-period step counter: ticks when the count reaches period-1,
// then wraps; a sync clear restarts the period from zero.
module step_timer #(
  parameter int unsigned CNT_W    = 5,
  parameter int unsigned PERIOD_W = 8
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                en_i,
  input  logic                clr_i,
  input  logic [PERIOD_W-1:0] period_i,
  output logic                tick_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last;

  assign last   = (PERIOD_W'(cnt_q) == (period_i - PERIOD_W'(1)));
  assign tick_o = en_i && last;

  // Clear wins over the wrap so a new period always starts from zero.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      if (last) cnt_d = '0;
      else      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/difficulty_scheduler.sv
// Game difficulty controller: start-level latch, hit-driven level-ups and a
// level-dependent step strobe.
module difficulty_scheduler
  import difficulty_pkg::*;
#(
  parameter int unsigned BASE_PERIOD    = 32,
  parameter int unsigned PERIOD_STEP    = 8,
  parameter int unsigned HITS_PER_LEVEL = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] sw,
  input  logic       start,
  input  logic       hit,
  input  logic       game_over,
  output logic [1:0] level,
  output logic [2:0] disp_code,
  output logic       step_tick,
  output logic       level_up,
  output logic       playing
);

  localparam int unsigned CNT_W = (BASE_PERIOD > 1) ? $clog2(BASE_PERIOD) : 1;
  localparam int unsigned HC_W  = (HITS_PER_LEVEL > 1) ? $clog2(HITS_PER_LEVEL) : 1;
  localparam logic [HC_W-1:0] HIT_LAST = HC_W'(HITS_PER_LEVEL - 1);

  state_t          state_q, state_d;
  level_t          level_q, level_d;
  logic [HC_W-1:0] hit_cnt_q, hit_cnt_d;
  logic            level_up_q, level_up_d;
  logic            timer_clr;
  logic            timer_en;
  logic [7:0]      period;

  always_comb begin
    state_d    = state_q;
    level_d    = level_q;
    hit_cnt_d  = hit_cnt_q;
    level_up_d = 1'b0;
    timer_clr  = 1'b0;
    case (state_q)
      IDLE: begin
        level_d = popcount3(sw);
        if (start) begin
          state_d   = RUN;
          hit_cnt_d = '0;
          timer_clr = 1'b1;
        end
      end
      RUN: begin
        // game_over takes priority: a simultaneous hit is dropped.
        if (game_over) begin
          state_d = OVER;
        end else if (hit) begin
          if (hit_cnt_q == HIT_LAST) begin
            hit_cnt_d = '0;
            if (level_q != MAX_LEVEL) begin
              level_d    = level_q + 2'd1;
              level_up_d = 1'b1;
              timer_clr  = 1'b1;
            end
          end else begin
            hit_cnt_d = hit_cnt_q + HC_W'(1);
          end
        end
      end
      OVER: begin
        if (start) begin
          state_d   = RUN;
          level_d   = popcount3(sw);
          hit_cnt_d = '0;
          timer_clr = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      level_q    <= '0;
      hit_cnt_q  <= '0;
      level_up_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      level_q    <= level_d;
      hit_cnt_q  <= hit_cnt_d;
      level_up_q <= level_up_d;
    end
  end

  assign timer_en = (state_q == RUN);
  assign period   = 8'(BASE_PERIOD) - 8'(PERIOD_STEP) * {6'b0, level_q};

  step_timer #(
    .CNT_W   (CNT_W),
    .PERIOD_W(8)
  ) u_step_timer (
    .clk_i   (clk),
    .rst_ni  (reset),
    .en_i    (timer_en),
    .clr_i   (timer_clr),
    .period_i(period),
    .tick_o  (step_tick)
  );

  assign level     = level_q;
  assign disp_code = therm_encode(level_q);
  assign level_up  = level_up_q;
  assign playing   = (state_q == RUN);

endmodule

// File: tb/tb_difficulty_scheduler.sv
// Directed bench for difficulty_scheduler with hand-computed tick/level timing.
module tb_difficulty_scheduler;

  logic       clk = 1'b0;
  logic       reset, start, hit, game_over;
  logic [2:0] sw;
  logic [1:0] level;
  logic [2:0] disp_code;
  logic       step_tick, level_up, playing;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int          cyc;
  int          ticks[$];
  int          lu_cnt;
  int          lu_cyc;
  int          exp_q[$];

  difficulty_scheduler #(
    .BASE_PERIOD   (32),
    .PERIOD_STEP   (8),
    .HITS_PER_LEVEL(8)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .sw       (sw),
    .start    (start),
    .hit      (hit),
    .game_over(game_over),
    .level    (level),
    .disp_code(disp_code),
    .step_tick(step_tick),
    .level_up (level_up),
    .playing  (playing)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // One clock: outputs are observed on the falling edge.
  task automatic step();
    @(negedge clk);
    cyc++;
    if (step_tick === 1'b1) ticks.push_back(cyc);
    if (level_up === 1'b1) begin
      lu_cnt++;
      lu_cyc = cyc;
    end
  endtask

  task automatic restart_log();
    cyc = 0;
    ticks.delete();
    lu_cnt = 0;
    lu_cyc = 0;
  endtask

  task automatic pulse_start();
    start = 1'b1; step(); start = 1'b0;
  endtask

  task automatic pulse_hit();
    hit = 1'b1; step(); hit = 1'b0;
  endtask

  task automatic pulse_over();
    game_over = 1'b1; step(); game_over = 1'b0;
  endtask

  task automatic run_to(input int c);
    while (cyc < c) step();
  endtask

  task automatic check_ticks(input string tag, input int exp[$]);
    check({tag, "_count"}, ticks.size(), exp.size());
    for (int i = 0; i < exp.size(); i++)
      if (i < ticks.size()) check({tag, "_cycle"}, ticks[i], exp[i]);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; hit = 1'b0; game_over = 1'b0; sw = 3'b101;
    restart_log();

    // Reset and IDLE preview
    step(); step();
    check("rst_level", level, 0);
    check("rst_disp", disp_code, 3'b000);
    check("rst_tick", step_tick, 0);
    check("rst_lvlup", level_up, 0);
    check("rst_playing", playing, 0);
    reset = 1'b1;
    step();
    check("preview_level", level, 2);
    check("preview_disp", disp_code, 3'b011);

    // Level 0 run, sw ignored while running
    sw = 3'b000;
    restart_log();
    pulse_start();
    check("run0_playing", playing, 1);
    check("run0_level", level, 0);
    run_to(40);
    sw = 3'b111;
    run_to(96);
    exp_q = '{32, 64, 96};
    check_ticks("run0_ticks", exp_q);
    check("run0_sw_ignored", level, 0);
    pulse_over();
    check("over_playing", playing, 0);

    // Level-up after 8 hits spaced 3 cycles
    sw = 3'b000;
    restart_log();
    pulse_start();
    for (int i = 0; i < 8; i++) begin
      pulse_hit(); step(); step();
    end
    check("lu_count", lu_cnt, 1);
    check("lu_cycle", lu_cyc, 23);
    check("lu_level", level, 1);
    check("lu_disp", disp_code, 3'b001);
    run_to(95);
    exp_q = '{46, 70, 94};
    check_ticks("lu_ticks", exp_q);
    pulse_over();

    // Saturation at level 3
    sw = 3'b110;
    restart_log();
    pulse_start();
    check("sat_start_level", level, 2);
    for (int i = 0; i < 16; i++) begin
      pulse_hit(); step();
    end
    check("sat_lu_count", lu_cnt, 1);
    check("sat_lu_cycle", lu_cyc, 16);
    check("sat_level", level, 3);
    check("sat_disp", disp_code, 3'b111);
    run_to(47);
    exp_q = '{23, 31, 39, 47};
    check_ticks("sat_ticks", exp_q);
    pulse_over();

    // hit and game_over together at hit_cnt 7
    sw = 3'b001;
    restart_log();
    pulse_start();
    for (int i = 0; i < 7; i++) pulse_hit();
    hit = 1'b1; game_over = 1'b1;
    step();
    hit = 1'b0; game_over = 1'b0;
    check("go_hit_playing", playing, 0);
    check("go_hit_level", level, 1);
    run_to(60);
    check("go_hit_no_ticks", ticks.size(), 0);
    check("go_hit_no_lu", lu_cnt, 0);
    check("go_hit_frozen_disp", disp_code, 3'b001);

    // Restart from OVER: fresh sample, cleared counters
    restart_log();
    pulse_start();
    check("restart_level", level, 1);
    check("restart_playing", playing, 1);
    run_to(24);
    exp_q = '{24};
    check_ticks("restart_ticks", exp_q);
    for (int i = 0; i < 7; i++) pulse_hit();
    check("restart_hit7_level", level, 1);
    pulse_hit();
    check("restart_hit8_level", level, 2);
    step(); step();

    // Reset mid-run at level 2
    reset = 1'b0;
    step();
    check("midrst_level", level, 0);
    check("midrst_playing", playing, 0);
    check("midrst_disp", disp_code, 3'b000);
    check("midrst_lvlup", level_up, 0);
    reset = 1'b1;
    restart_log();
    run_to(40);
    check("midrst_no_ticks", ticks.size(), 0);
    check("midrst_idle_playing", playing, 0);
    check("midrst_preview", level, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
